// File: rtl/lutram_mp_clr.sv
// Multi-port distributed RAM: one write port, NUM_RD independent read ports.
// Read data is either combinational or registered (optional write-first
// forwarding). A clear sequencer fills every word with CLR_WORD after reset
// and/or on a CLR pulse, holding off user writes while BUSY is high.
module lutram_mp_clr #(
    parameter int DATA_W      = 2,
    parameter int ADDR_W      = 5,
    parameter int NUM_RD      = 8,
    parameter int OUT_REG     = 0,
    parameter int WRITE_FIRST = 0,
    parameter int CLR_ON_RST  = 1,
    parameter logic [DATA_W-1:0] CLR_WORD = '0
) (
    input  logic                       WCLK,
    input  logic                       RST_N,
    input  logic                       CLR,
    output logic                       BUSY,
    input  logic                       WE,
    input  logic [ADDR_W-1:0]          WADDR,
    input  logic [DATA_W-1:0]          DIN,
    input  logic [NUM_RD*ADDR_W-1:0]   RADDR,
    output logic [NUM_RD*DATA_W-1:0]   DOUT
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;
    localparam logic [0:0] ST_RESET = (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;

    // Last address of the clear walk; comparing against it keeps the counter
    // from ever stepping past DEPTH-1 (also correct for ADDR_W=1).
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

    // Forwarding only matters for the registered read path.
    localparam bit FWD_EN = (WRITE_FIRST != 0);

    logic [0:0]        state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic              user_we;

    // Storage has no reset; contents are defined only after a clear or writes.
    logic [DATA_W-1:0] mem [DEPTH];

    // User writes are dropped while the clear sequence owns the array.
    assign user_we = WE && (state_reg == ST_IDLE);
    assign BUSY    = (state_reg == ST_CLEAR);

    // Clear sequencer next-state: walk 0..DEPTH-1 once, CLR only honoured in IDLE.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (CLR) begin
                    state_next = ST_CLEAR;
                    cnt_next   = '0;
                end
            end
            default: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + ADDR_W'(1);
                end
            end
        endcase
    end

    // Sequencer state and counter; reset lands in the configured reset state.
    always_ff @(posedge WCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= ST_RESET;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Single write port shared by the clear walk and user writes.
    always_ff @(posedge WCLK) begin
        if (state_reg == ST_CLEAR) begin
            mem[cnt_reg] <= CLR_WORD;
        end else if (user_we) begin
            mem[WADDR] <= DIN;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] raddr_k;
            logic [DATA_W-1:0] rd_data;
            logic [DATA_W-1:0] dout_reg;

            assign raddr_k = RADDR[gi*ADDR_W +: ADDR_W];
            assign rd_data = mem[raddr_k];

            // Registered read; a user write to this address may bypass the
            // array when write-first is selected. Clear writes never bypass.
            always_ff @(posedge WCLK or negedge RST_N) begin
                if (!RST_N) begin
                    dout_reg <= '0;
                end else if (FWD_EN && user_we && (WADDR == raddr_k)) begin
                    dout_reg <= DIN;
                end else begin
                    dout_reg <= rd_data;
                end
            end

            assign DOUT[gi*DATA_W +: DATA_W] = (OUT_REG != 0) ? dout_reg : rd_data;
        end
    endgenerate

endmodule

// File: tb/tb_lutram_mp_clr.sv
// Scoreboard bench for lutram_mp_clr: stimulus threads queue expected values
// tagged with the cycle they are due; a negedge monitor pops and compares.
module tb_lutram_mp_clr;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // dut 0: default geometry, async read, CLR_WORD=01
    logic        clr0, we0, busy0;
    logic [4:0]  waddr0;
    logic [1:0]  din0;
    logic [39:0] raddr0;
    logic [15:0] dout0;
    // dut 1 (write-first) and dut 2 (read-first) share stimulus, registered read
    logic        clr12, we12, busy1, busy2;
    logic [4:0]  waddr12;
    logic [1:0]  din12;
    logic [39:0] raddr12;
    logic [15:0] dout1, dout2;
    // dut 3: DATA_W=8 ADDR_W=6 NUM_RD=3
    logic        clr3, we3, busy3;
    logic [5:0]  waddr3;
    logic [7:0]  din3;
    logic [17:0] raddr3;
    logic [23:0] dout3;
    // dut 4: DEPTH=2
    logic        clr4, we4, busy4;
    logic [0:0]  waddr4;
    logic [3:0]  din4;
    logic [1:0]  raddr4;
    logic [7:0]  dout4;

    lutram_mp_clr #(.CLR_WORD(2'b01)) u0 (
        .WCLK(clk), .RST_N(rst_n), .CLR(clr0), .BUSY(busy0), .WE(we0),
        .WADDR(waddr0), .DIN(din0), .RADDR(raddr0), .DOUT(dout0));
    lutram_mp_clr #(.OUT_REG(1), .WRITE_FIRST(1)) u1 (
        .WCLK(clk), .RST_N(rst_n), .CLR(clr12), .BUSY(busy1), .WE(we12),
        .WADDR(waddr12), .DIN(din12), .RADDR(raddr12), .DOUT(dout1));
    lutram_mp_clr #(.OUT_REG(1), .WRITE_FIRST(0)) u2 (
        .WCLK(clk), .RST_N(rst_n), .CLR(clr12), .BUSY(busy2), .WE(we12),
        .WADDR(waddr12), .DIN(din12), .RADDR(raddr12), .DOUT(dout2));
    lutram_mp_clr #(.DATA_W(8), .ADDR_W(6), .NUM_RD(3), .CLR_WORD(8'hA5)) u3 (
        .WCLK(clk), .RST_N(rst_n), .CLR(clr3), .BUSY(busy3), .WE(we3),
        .WADDR(waddr3), .DIN(din3), .RADDR(raddr3), .DOUT(dout3));
    lutram_mp_clr #(.DATA_W(4), .ADDR_W(1), .NUM_RD(2), .CLR_WORD(4'h3)) u4 (
        .WCLK(clk), .RST_N(rst_n), .CLR(clr4), .BUSY(busy4), .WE(we4),
        .WADDR(waddr4), .DIN(din4), .RADDR(raddr4), .DOUT(dout4));

    typedef struct {
        int    due;
        int    dut;
        int    port;   // -1 selects BUSY
        int    exp;
        string name;
    } sb_item_t;

    sb_item_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic push(input int due, input int dut, input int port,
                        input int exp, input string name);
        sb_item_t it;
        it.due  = due;
        it.dut  = dut;
        it.port = port;
        it.exp  = exp;
        it.name = name;
        sb.push_back(it);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    function automatic int actual(input int dut, input int port);
        int v;
        v = -1;
        if (port < 0) begin
            case (dut)
                0: v = int'(busy0);
                1: v = int'(busy1);
                2: v = int'(busy2);
                3: v = int'(busy3);
                default: v = int'(busy4);
            endcase
        end else begin
            case (dut)
                0: v = int'(dout0[port*2 +: 2]);
                1: v = int'(dout1[port*2 +: 2]);
                2: v = int'(dout2[port*2 +: 2]);
                3: v = int'(dout3[port*8 +: 8]);
                default: v = int'(dout4[port*4 +: 4]);
            endcase
        end
        return v;
    endfunction

    // Monitor: compare every entry whose due cycle is the current one.
    always @(negedge clk) begin
        int i;
        int act;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due <= cyc) begin
                act = actual(sb[i].dut, sb[i].port);
                checks++;
                if (sb[i].due < cyc || act != sb[i].exp) begin
                    errors++;
                    $display("FAIL %s dut=%0d port=%0d cyc=%0d got=%0h exp=%0h",
                             sb[i].name, sb[i].dut, sb[i].port, cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    int c0, m, r, n, k4;
    int ra [8];
    int rv [8];

    initial begin
        {clr0, we0, waddr0, din0, raddr0} = '0;
        {clr12, we12, waddr12, din12, raddr12} = '0;
        {clr3, we3, waddr3, din3, raddr3} = '0;
        {clr4, we4, waddr4, din4, raddr4} = '0;

        // Reset state: BUSY high (CLR_ON_RST), registered DOUT forced to 0.
        next();
        push(cyc, 0, -1, 1, "rst_busy0");
        push(cyc, 4, -1, 1, "rst_busy4");
        for (int k = 0; k < 8; k++) push(cyc, 1, k, 0, "rst_dout1");
        next();
        rst_n = 1'b1;
        c0 = cyc;

        // Post-reset clear lengths: 32, 64 and 2 cycles.
        for (int k = 0; k < 32; k++) push(c0 + k, 0, -1, 1, "pwr_busy0");
        push(c0 + 32, 0, -1, 0, "pwr_done0");
        push(c0 + 31, 1, -1, 1, "pwr_busy1");
        push(c0 + 32, 2, -1, 0, "pwr_done2");
        push(c0 + 1, 4, -1, 1, "pwr_busy4");
        push(c0 + 2, 4, -1, 0, "pwr_done4");
        push(c0 + 63, 3, -1, 1, "pwr_busy3");
        push(c0 + 64, 3, -1, 0, "pwr_done3");

        fork
            begin : thr_a
                // Write during the 5th clear cycle must be dropped.
                repeat (4) next();
                we0 = 1'b1; waddr0 = 5'd3; din0 = 2'b10;
                next();
                we0 = 1'b0;
                while (cyc < c0 + 32) next();
                // Every port, every address reads CLR_WORD.
                for (int a = 0; a < 32; a++) begin
                    for (int k = 0; k < 8; k++) begin
                        raddr0[k*5 +: 5] = 5'((a + k * 4) % 32);
                        push(cyc, 0, k, 1, "clr_rd");
                    end
                    next();
                end
                raddr0[4:0] = 5'd3;
                push(cyc, 0, 0, 1, "drop_wr3");
                next();
                // Async read: old value in the write cycle, new after the edge.
                we0 = 1'b1; waddr0 = 5'd7; din0 = 2'b11;
                for (int k = 0; k < 8; k++) begin
                    raddr0[k*5 +: 5] = 5'd7;
                    push(cyc, 0, k, 1, "rd_old7");
                end
                next();
                we0 = 1'b0;
                for (int k = 0; k < 8; k++) push(cyc, 0, k, 3, "rd_new7");
                // Scattered writes then readback through all ports.
                we0 = 1'b1; waddr0 = 5'd1;  din0 = 2'b10; next();
                waddr0 = 5'd12; din0 = 2'b11; next();
                waddr0 = 5'd30; din0 = 2'b00; next();
                waddr0 = 5'd31; din0 = 2'b10; next();
                we0 = 1'b0;
                ra = '{1, 12, 30, 31, 7, 3, 0, 2};
                rv = '{2, 3, 0, 2, 3, 1, 1, 1};
                for (int k = 0; k < 8; k++) begin
                    raddr0[k*5 +: 5] = 5'(ra[k]);
                    push(cyc, 0, k, rv[k], "wr_rd");
                end
                next();
                // CLR pulse; a second pulse mid-clear must not extend BUSY.
                m = cyc;
                clr0 = 1'b1;
                push(m, 0, -1, 0, "clr_idle");
                next();
                clr0 = 1'b0;
                for (int k = 1; k <= 32; k++) push(m + k, 0, -1, 1, "clr_busy");
                push(m + 33, 0, -1, 0, "clr_done");
                while (cyc < m + 10) next();
                clr0 = 1'b1;
                next();
                clr0 = 1'b0;
                while (cyc < m + 33) next();
                for (int a = 0; a < 32; a++) begin
                    for (int k = 0; k < 8; k++) begin
                        raddr0[k*5 +: 5] = 5'((a + k) % 32);
                        push(cyc, 0, k, 1, "reclr_rd");
                    end
                    next();
                end
            end
            begin : thr_b
                while (cyc < c0 + 32) next();
                for (int k = 0; k < 8; k++) begin
                    raddr12[k*5 +: 5] = 5'(k * 3 + 1);
                    push(cyc + 1, 1, k, 0, "reg_clr1");
                    push(cyc + 1, 2, k, 0, "reg_clr2");
                end
                we12 = 1'b1; waddr12 = 5'd9; din12 = 2'b01;
                next();
                // Write 10 to address 9 while ports 2 and 6 read it.
                n = cyc;
                din12 = 2'b10;
                raddr12[2*5 +: 5] = 5'd9;
                raddr12[6*5 +: 5] = 5'd9;
                push(n + 1, 1, 2, 2, "wf_fwd_p2");
                push(n + 1, 1, 6, 2, "wf_fwd_p6");
                push(n + 1, 2, 2, 1, "rf_old_p2");
                push(n + 1, 2, 6, 1, "rf_old_p6");
                push(n + 1, 1, 5, 0, "wf_other");
                push(n + 1, 2, 5, 0, "rf_other");
                next();
                we12 = 1'b0;
                push(n + 2, 1, 2, 2, "wf_hold");
                push(n + 2, 2, 2, 2, "rf_new");
                next();
                // One-cycle read latency on port 0.
                raddr12[4:0] = 5'd9;
                push(cyc, 1, 0, 0, "lat_before");
                push(cyc + 1, 1, 0, 2, "lat_after");
                next();
                next();
            end
            begin : thr_c
                // DEPTH=2 instance: slicing, writes, repeated clears.
                while (cyc < c0 + 2) next();
                raddr4 = 2'b10;
                push(cyc, 4, 0, 'h3, "d2_clr_p0");
                push(cyc, 4, 1, 'h3, "d2_clr_p1");
                we4 = 1'b1; waddr4 = 1'b1; din4 = 4'hC;
                next();
                we4 = 1'b0;
                push(cyc, 4, 1, 'hC, "d2_wr_p1");
                push(cyc, 4, 0, 'h3, "d2_keep_p0");
                for (int rep = 0; rep < 2; rep++) begin
                    k4 = cyc;
                    clr4 = 1'b1;
                    next();
                    clr4 = 1'b0;
                    push(k4 + 1, 4, -1, 1, "d2_busy_a");
                    push(k4 + 2, 4, -1, 1, "d2_busy_b");
                    push(k4 + 3, 4, -1, 0, "d2_done");
                    while (cyc < k4 + 3) next();
                    push(cyc, 4, 0, 'h3, "d2_reclr_p0");
                    push(cyc, 4, 1, 'h3, "d2_reclr_p1");
                end
                // Wide instance: 3 ports, 8-bit words.
                while (cyc < c0 + 64) next();
                for (int a = 0; a < 64; a++) begin
                    raddr3[5:0]   = 6'(a);
                    raddr3[11:6]  = 6'(63 - a);
                    raddr3[17:12] = 6'((a * 5) % 64);
                    for (int k = 0; k < 3; k++) push(cyc, 3, k, 'hA5, "w8_clr");
                    next();
                end
                we3 = 1'b1; waddr3 = 6'd63; din3 = 8'h5A;
                next();
                waddr3 = 6'd32; din3 = 8'hF0;
                next();
                we3 = 1'b0;
                raddr3 = {6'd63, 6'd32, 6'd63};
                push(cyc, 3, 0, 'h5A, "w8_p0");
                push(cyc, 3, 1, 'hF0, "w8_p1");
                push(cyc, 3, 2, 'h5A, "w8_p2");
                next();
            end
        join

        // Reset asserted at clear cycle 12; clear must restart and finish.
        for (int a = 20; a < 32; a++) begin
            we0 = 1'b1; waddr0 = 5'(a); din0 = 2'b10;
            next();
        end
        we0 = 1'b0;
        m = cyc;
        clr0 = 1'b1;
        next();
        clr0 = 1'b0;
        while (cyc < m + 12) next();
        rst_n = 1'b0;
        push(cyc, 0, -1, 1, "rstmid_busy0");
        push(cyc, 1, 0, 0, "rstmid_dout1");
        next();
        push(cyc, 4, -1, 1, "rstmid_busy4");
        next();
        rst_n = 1'b1;
        r = cyc;
        for (int k = 0; k < 32; k++) push(r + k, 0, -1, 1, "rst_busy");
        push(r + 32, 0, -1, 0, "rst_done");
        push(r + 2, 4, -1, 0, "rst_done4");
        push(r + 63, 3, -1, 1, "rst_busy3");
        push(r + 64, 3, -1, 0, "rst_done3");
        while (cyc < r + 32) next();
        for (int a = 0; a < 32; a++) begin
            for (int k = 0; k < 8; k++) begin
                raddr0[k*5 +: 5] = 5'((a + 5 * k) % 32);
                push(cyc, 0, k, 1, "rst_clr_rd");
            end
            next();
        end
        while (cyc < r + 66) next();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got=%0d exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
